// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd_if: control pulses into the stopwatch and display/status out.
//   master (controller/bench): drives tick, start_stop, clear, lap;
//                               sees bcd, running, overflow, lap_active
//   slave  (stopwatch_bcd):    the reverse
interface stopwatch_bcd_if #(
  parameter int N_DIGITS = 4
);
  logic                    tick;
  logic                    start_stop;
  logic                    clear;
  logic                    lap;
  logic [4*N_DIGITS-1:0]   bcd;
  logic                    running;
  logic                    overflow;
  logic                    lap_active;

  modport master (
    output tick, start_stop, clear, lap,
    input  bcd, running, overflow, lap_active
  );

  modport slave (
    input  tick, start_stop, clear, lap,
    output bcd, running, overflow, lap_active
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: decimal stopwatch. Counts rising edges of tick while running,
// as N_DIGITS packed BCD digits (digit 0 in bits [3:0]).
//   clkin  : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sw     : stopwatch_bcd_if.slave
//            in  tick, start_stop, clear, lap (single-cycle pulses)
//            out bcd (display value), running, overflow (sticky), lap_active
// Optional feature macro: STOPWATCH_LAP_HOLD_EN enables lap hold (display
// freeze while the live count keeps advancing). Undefined: lap is ignored.

// One BCD digit of the counter chain; carries out when it wraps 9 -> 0.
module stopwatch_bcd_digit (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  assign cout = cin & (d == 4'd9);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)   d <= 4'd0;
    else if (clr) d <= 4'd0;
    else if (cin) d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
  end
endmodule

module stopwatch_bcd #(
  parameter int N_DIGITS = 4
) (
  input logic            clkin,
  input logic            rst_n,
  stopwatch_bcd_if.slave sw
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                    state_q, state_d;
  logic                      tick_d, tick_evt;
  logic                      inc, clr_acc, pause_evt;
  logic [N_DIGITS:0]         carry;
  logic [N_DIGITS-1:0][3:0]  cnt;
  logic                      running_q, overflow_q;

  assign tick_evt  = sw.tick & ~tick_d;
  // RUN counts even in the cycle it is left; entering RUN does not count.
  assign inc       = (state_q == RUN) & tick_evt;
  // Clear is only honoured when stopped, and beats start_stop there.
  assign clr_acc   = sw.clear & (state_q != RUN);
  assign pause_evt = (state_q == RUN) & sw.start_stop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:         if (sw.start_stop) state_d = PAUSE;
      IDLE, PAUSE: if (sw.clear)      state_d = IDLE;
                   else if (sw.start_stop) state_d = RUN;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_d     <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_d     <= sw.tick;
      // Decode the next state so running lines up with state_q == RUN.
      running_q  <= (state_d == RUN);
      if (clr_acc)               overflow_q <= 1'b0;
      else if (carry[N_DIGITS])  overflow_q <= 1'b1;
    end
  end

  // Ripple-carry digit chain: digit i steps when all lower digits are 9.
  assign carry[0] = inc;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    stopwatch_bcd_digit u_dig (
      .clkin (clkin),
      .rst_n (rst_n),
      .clr   (clr_acc),
      .cin   (carry[i]),
      .d     (cnt[i]),
      .cout  (carry[i+1])
    );
  end

  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                     hold_q;
  logic [N_DIGITS-1:0][3:0] disp_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      disp_q <= '0;
    end else if (clr_acc || pause_evt) begin
      hold_q <= 1'b0;
    end else if ((state_q == RUN) && sw.lap) begin
      // Snapshot the value currently on display when entering hold.
      if (!hold_q) disp_q <= cnt;
      hold_q <= ~hold_q;
    end
  end

  assign sw.bcd        = hold_q ? disp_q : cnt;
  assign sw.lap_active = hold_q;
`else
  logic unused_lap;
  assign unused_lap    = sw.lap ^ pause_evt;
  assign sw.bcd        = cnt;
  assign sw.lap_active = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;
  localparam int N   = 4;
  localparam int MOD = 10000;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkin = ~clkin;

  stopwatch_bcd_if #(.N_DIGITS(N)) sw ();
  stopwatch_bcd #(.N_DIGITS(N)) dut (.clkin(clkin), .rst_n(rst_n), .sw(sw));

  typedef struct {
    logic [4*N-1:0] bcd;
    logic           running;
    logic           overflow;
    logic           lap_active;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: elapsed count as a plain integer mod 10^N.
  int m_cnt, m_disp;
  bit m_run, m_ovf, m_hold, m_tick_d;

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_disp = 0; m_run = 0; m_ovf = 0; m_hold = 0; m_tick_d = 0;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic t, input logic s, input logic c, input logic l);
    exp_t e;
    bit   was_run, inc, cacc;
    int   old;
    @(negedge clkin); #1;
    sw.tick = t; sw.start_stop = s; sw.clear = c; sw.lap = l;
    was_run = m_run;
    old     = m_cnt;
    inc     = was_run && t && !m_tick_d;
    cacc    = c && !was_run;
    if (cacc) begin
      m_cnt = 0; m_ovf = 0;
    end else if (inc) begin
      m_cnt = (m_cnt + 1) % MOD;
      if (m_cnt == 0) m_ovf = 1;
    end
`ifdef STOPWATCH_LAP_HOLD_EN
    if (cacc || (was_run && s)) m_hold = 0;
    else if (was_run && l) begin
      if (!m_hold) m_disp = old;
      m_hold = !m_hold;
    end
`endif
    if (was_run) begin
      if (s) m_run = 0;
    end else if (!c && s) m_run = 1;
    m_tick_d = t;
    e.bcd        = to_bcd(m_hold ? m_disp : m_cnt);
    e.running    = m_run;
    e.overflow   = m_ovf;
    e.lap_active = m_hold;
    q.push_back(e);
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkin);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_bcd",      64'(sw.bcd),        64'(e.bcd));
        chk("sb_running",  64'(sw.running),    64'(e.running));
        chk("sb_overflow", 64'(sw.overflow),   64'(e.overflow));
        chk("sb_lap",      64'(sw.lap_active), 64'(e.lap_active));
      end
    end
  end

  initial begin
    sw.tick = 0; sw.start_stop = 0; sw.clear = 0; sw.lap = 0;
    model_reset();
    repeat (3) @(negedge clkin);
    chk("rst_bcd",      64'(sw.bcd),        64'h0);
    chk("rst_running",  64'(sw.running),    64'h0);
    chk("rst_overflow", 64'(sw.overflow),   64'h0);
    chk("rst_lap",      64'(sw.lap_active), 64'h0);
    #1 rst_n = 1'b1;

    // Start, 12 ticks.
    cyc(0, 1, 0, 0);
    tk(12);
    chk("run12_bcd",     64'(sw.bcd),     64'h0012);
    chk("run12_running", 64'(sw.running), 64'h1);

    // Asynchronous reset mid-run, between clock edges.
    @(negedge clkin); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd",     64'(sw.bcd),      64'h0);
    chk("arst_running", 64'(sw.running),  64'h0);
    sw.tick = 0; sw.start_stop = 0;
    model_reset();
    @(negedge clkin); #1 rst_n = 1'b1;

    // Tick while IDLE is ignored; then held-high tick counts once.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    tk(3);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_bcd", 64'(sw.bcd), 64'h0004);

    // Pause with coincident tick counts; resume with coincident tick does not.
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pause_tick_bcd", 64'(sw.bcd),     64'h0005);
    chk("pause_running",  64'(sw.running), 64'h0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("resume_tick_bcd", 64'(sw.bcd),     64'h0005);
    chk("resume_running",  64'(sw.running), 64'h1);

    // Clear in RUN ignored; clear + start_stop in PAUSE goes to IDLE.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("clr_run_bcd", 64'(sw.bcd), 64'h0005);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("clr_ss_bcd",     64'(sw.bcd),     64'h0);
    chk("clr_ss_running", 64'(sw.running), 64'h0);

`ifdef STOPWATCH_LAP_HOLD_EN
    cyc(0, 1, 0, 0);
    tk(25);
    cyc(0, 0, 0, 1);
    tk(5);
    chk("lap_hold_bcd", 64'(sw.bcd),        64'h0025);
    chk("lap_hold_act", 64'(sw.lap_active), 64'h1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("lap_rel_bcd", 64'(sw.bcd),        64'h0030);
    chk("lap_rel_act", 64'(sw.lap_active), 64'h0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
`endif

    // Full-count wrap and sticky overflow.
    cyc(0, 1, 0, 0);
    tk(MOD - 1);
    chk("full_bcd", 64'(sw.bcd),      64'h9999);
    chk("full_ovf", 64'(sw.overflow), 64'h0);
    tk(1);
    chk("wrap_bcd", 64'(sw.bcd),      64'h0000);
    chk("wrap_ovf", 64'(sw.overflow), 64'h1);
    tk(3);
    chk("ovf_sticky", 64'(sw.overflow), 64'h1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_clr_bcd", 64'(sw.bcd),      64'h0);
    chk("ovf_clr",     64'(sw.overflow), 64'h0);

    // Randomized traffic, scored by the monitor.
    repeat (3000) begin
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 5) == 0));
    end
    cyc(0, 0, 0, 0);
    repeat (2) @(negedge clkin);
    #1;
    chk("sb_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
